// File: rtl/interboard_pkg.sv
// interboard_pkg
// Definitions shared by both ends of the Request/Ack interboard link: the
// frame length, the bit positions of each field inside the four 6-bit words,
// the msg_type encodings, and the receiver FSM state type.
//
// Frame layout (word index 0..3):
//   W0 = {msg_type[3:0], move_dir, rst_flag}
//   W1 = card[5:0]
//   W2 = {block_y[2:0], sel_len[2:0]}
//   W3 = {1'b0, block_x[4:0]}   (MSB ignored by the receiver)
package interboard_pkg;

    localparam int WORD_W      = 6;
    localparam int FRAME_WORDS = 4;
    localparam int IDX_W       = $clog2(FRAME_WORDS);

    // W0
    localparam int W0_RST_BIT  = 0;
    localparam int W0_DIR_BIT  = 1;
    localparam int W0_MSG_LSB  = 2;
    localparam int W0_MSG_MSB  = 5;
    // W1
    localparam int W1_CARD_LSB = 0;
    localparam int W1_CARD_MSB = 5;
    // W2
    localparam int W2_SEL_LSB  = 0;
    localparam int W2_SEL_MSB  = 2;
    localparam int W2_Y_LSB    = 3;
    localparam int W2_Y_MSB    = 5;
    // W3
    localparam int W3_X_LSB    = 0;
    localparam int W3_X_MSB    = 4;

    // msg_type encodings; the transmitter builds W0 from these same values.
    typedef enum logic [3:0] {
        MSG_NONE     = 4'd0,
        MSG_MOVE     = 4'd1,
        MSG_SELECT   = 4'd2,
        MSG_PLACE    = 4'd3,
        MSG_SWAP     = 4'd4,
        MSG_CLEAR    = 4'd5,
        MSG_TURN     = 4'd6,
        MSG_GAMEOVER = 4'd7
    } msg_type_e;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_ACKED  = 2'd1,
        RX_COMMIT = 2'd2
    } rx_state_e;

endpackage

// File: rtl/interboard_receiver_sync_ff.sv
// sync_ff
// STAGES-deep flip-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk_i  - destination clock
//   rst_ni - synchronous active-low reset, clears every stage
//   d_i    - asynchronous input
//   q_o    - synchronized output (STAGES cycles of latency)
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) ff_q <= '0;
        else         ff_q <= {ff_q[STAGES-2:0], d_i};
    end

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/interboard_receiver.sv
// interboard_receiver
// Receiving end of the four-phase Request/Ack interboard link. Collects four
// 6-bit words per frame, decodes them into the interboard_* fields and pulses
// interboard_en (normal frame) or interboard_rst (reset frame).
//
// Optional feature macro: INTERBOARD_RX_TIMEOUT_EN
//   defined   - a mid-frame stall of TIMEOUT_CYCLES aborts the frame and
//               pulses rx_error.
//   undefined - no timeout; rx_error is tied low.
//
// Ports:
//   clk                  - system clock
//   rst                  - synchronous active-low reset
//   Request              - asynchronous strobe from the peer board
//   interboard_data[5:0] - word from the peer, stable while Request is high
//   Ack                  - registered handshake acknowledge
//   interboard_en        - 1-cycle pulse, normal frame complete
//   interboard_rst       - 1-cycle pulse, reset frame complete
//   interboard_move_dir, interboard_msg_type, interboard_card,
//   interboard_block_x, interboard_block_y, interboard_sel_len
//                        - decoded fields, held until the next frame
//   rx_error             - 1-cycle pulse on a frame abort
module interboard_receiver
    import interboard_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Request,
    input  logic [5:0]  interboard_data,
    output logic        Ack,
    output logic        interboard_en,
    output logic        interboard_rst,
    output logic        interboard_move_dir,
    output logic [3:0]  interboard_msg_type,
    output logic [5:0]  interboard_card,
    output logic [4:0]  interboard_block_x,
    output logic [2:0]  interboard_block_y,
    output logic [2:0]  interboard_sel_len,
    output logic        rx_error
);

    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 2) begin : g_param_chk
        $error("interboard_receiver: SYNC_STAGES and TIMEOUT_CYCLES must be >= 2");
    end

    logic req_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_req_sync (
        .clk_i (clk),
        .rst_ni(rst),
        .d_i   (Request),
        .q_o   (req_s)
    );

    rx_state_e                               state_q;
    logic [IDX_W-1:0]                        idx_q;
    logic [FRAME_WORDS-1:0][WORD_W-1:0]      words_q;
    logic                                    ack_q, en_q, rst_q, err_q;
    logic                                    dir_q;
    logic [3:0]                              msg_q;
    logic [5:0]                              card_q;
    logic [4:0]                              bx_q;
    logic [2:0]                              by_q, sel_q;

    // Field decode from the word buffer; only loaded into the outputs in COMMIT.
    logic       rstf_d, dir_d;
    logic [3:0] msg_d;
    logic [5:0] card_d;
    logic [4:0] bx_d;
    logic [2:0] by_d, sel_d;

    always_comb begin
        rstf_d = words_q[0][W0_RST_BIT];
        dir_d  = words_q[0][W0_DIR_BIT];
        msg_d  = words_q[0][W0_MSG_MSB:W0_MSG_LSB];
        card_d = words_q[1][W1_CARD_MSB:W1_CARD_LSB];
        sel_d  = words_q[2][W2_SEL_MSB:W2_SEL_LSB];
        by_d   = words_q[2][W2_Y_MSB:W2_Y_LSB];
        bx_d   = words_q[3][W3_X_MSB:W3_X_LSB];
    end

    // W3 MSB is carried in the buffer but carries no field.
    logic unused_w3_msb;
    assign unused_w3_msb = words_q[3][WORD_W-1];

`ifdef INTERBOARD_RX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             state_chg, tmo_busy, tmo_hit;

    // Mirrors the FSM transition conditions so the counter restarts on each move.
    assign state_chg = (state_q == RX_IDLE  &&  req_s) ||
                       (state_q == RX_ACKED && !req_s) ||
                       (state_q == RX_COMMIT);
    assign tmo_busy  = (state_q == RX_ACKED) || (state_q == RX_IDLE && idx_q != '0);
    assign tmo_hit   = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RX_IDLE;
            idx_q   <= '0;
            words_q <= '0;
            ack_q   <= 1'b0;
            en_q    <= 1'b0;
            rst_q   <= 1'b0;
            err_q   <= 1'b0;
            dir_q   <= 1'b0;
            msg_q   <= '0;
            card_q  <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            sel_q   <= '0;
`ifdef INTERBOARD_RX_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            en_q  <= 1'b0;
            rst_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                RX_IDLE: begin
                    if (req_s) begin
                        words_q[idx_q] <= interboard_data;
                        ack_q          <= 1'b1;
                        state_q        <= RX_ACKED;
                    end
                end
                RX_ACKED: begin
                    if (!req_s) begin
                        ack_q <= 1'b0;
                        if (idx_q == IDX_W'(FRAME_WORDS - 1)) begin
                            idx_q   <= '0;
                            state_q <= RX_COMMIT;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= RX_IDLE;
                        end
                    end
                end
                RX_COMMIT: begin
                    dir_q   <= dir_d;
                    msg_q   <= msg_d;
                    card_q  <= card_d;
                    bx_q    <= bx_d;
                    by_q    <= by_d;
                    sel_q   <= sel_d;
                    rst_q   <= rstf_d;
                    en_q    <= !rstf_d;
                    state_q <= RX_IDLE;
                end
                default: state_q <= RX_IDLE;
            endcase
`ifdef INTERBOARD_RX_TIMEOUT_EN
            // A stall only aborts when no transition happens in the same cycle,
            // so the abort assignments below never collide with the case above.
            if (state_chg || !tmo_busy) begin
                tmo_cnt_q <= '0;
            end else if (tmo_hit) begin
                tmo_cnt_q <= '0;
                ack_q     <= 1'b0;
                idx_q     <= '0;
                state_q   <= RX_IDLE;
                err_q     <= 1'b1;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
`endif
        end
    end

    assign Ack                 = ack_q;
    assign interboard_en       = en_q;
    assign interboard_rst      = rst_q;
    assign interboard_move_dir = dir_q;
    assign interboard_msg_type = msg_q;
    assign interboard_card     = card_q;
    assign interboard_block_x  = bx_q;
    assign interboard_block_y  = by_q;
    assign interboard_sel_len  = sel_q;
    assign rx_error            = err_q;

endmodule
